upsampling2x2: RTL and testbench

//  Nearest-neighbour 2x2 upsampler (inverse direction of the 2x2 max-pool stage).

---
 rtl/upsampling2x2.sv | 114 +++++++++++
 tb/tb_upsampling2x2.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/upsampling2x2.sv
// Nearest-neighbour 2x2 upsampler: every input pixel is emitted twice per row, every row twice.
// Latency: the first copy of a pixel appears on o_data one cycle after its transfer.
// Backpressure: i_ready=1 only in FILL with dup=0, so at most one input per 2 cycles and none during REPLAY.
//
// Ports:
//   clk, rst_n            clock (rising edge) and synchronous active-low reset
//   i_valid/i_data        input pixel stream, raster order
//   i_ready               combinational from state; a transfer is i_valid && i_ready
//   o_valid/o_data        registered output pixel stream, raster order, 2W x 2H
//   o_frame_done          registered 1-cycle pulse alongside the last output pixel of a frame
module upsampling2x2 #(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 4,
    parameter int IMAGE_HEIGHT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_frame_done
);

    localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    state_t                state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  dup;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] row_buf [IMAGE_WIDTH];

    assign i_ready = (state == FILL) && !dup;
    assign xfer    = i_valid && i_ready;

    // Row buffer has no reset: every entry is rewritten during FILL before
    // REPLAY reads it, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (rst_n && xfer) begin
            row_buf[col] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FILL;
            col          <= '0;
            row          <= '0;
            dup          <= 1'b0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                FILL: begin
                    if (!dup) begin
                        // Only place a bubble can appear: waiting on upstream.
                        if (xfer) begin
                            o_data  <= i_data;
                            o_valid <= 1'b1;
                            dup     <= 1'b1;
                        end else begin
                            o_valid <= 1'b0;
                        end
                    end else begin
                        // Second copy: o_data simply held.
                        o_valid <= 1'b1;
                        dup     <= 1'b0;
                        if (col == COL_LAST) begin
                            col   <= '0;
                            state <= REPLAY;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                REPLAY: begin
                    o_valid <= 1'b1;
                    if (!dup) begin
                        o_data <= row_buf[col];
                        dup    <= 1'b1;
                    end else begin
                        dup <= 1'b0;
                        if (col == COL_LAST) begin
                            col   <= '0;
                            state <= FILL;
                            if (row == ROW_LAST) begin
                                row          <= '0;
                                o_frame_done <= 1'b1;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_upsampling2x2.sv
// Bench for upsampling2x2: a 4x2 instance for rows, gaps, frames and reset,
// plus a 2x1 instance for the minimum-size case.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_upsampling2x2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_i_valid, a_i_ready, a_o_valid, a_o_frame_done;
    logic [31:0] a_i_data, a_o_data;
    logic        b_i_valid, b_i_ready, b_o_valid, b_o_frame_done;
    logic [31:0] b_i_data, b_o_data;

    upsampling2x2 #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_valid(a_i_valid), .i_data(a_i_data), .i_ready(a_i_ready),
        .o_data(a_o_data), .o_valid(a_o_valid), .o_frame_done(a_o_frame_done)
    );

    upsampling2x2 #(.DATA_WIDTH(32), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_valid(b_i_valid), .i_data(b_i_data), .i_ready(b_i_ready),
        .o_data(b_o_data), .o_valid(b_o_valid), .o_frame_done(b_o_frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] a_in[$];
    logic [31:0] a_exp[$];
    int          gap_after, gap_left;
    int          bubbles, fd_cnt, fd_idx, out_cnt, lat;
    logic [15:0] rdy_bits;

    // Queue input pixels p[first..3] and the expected output row:
    // each pixel twice, then the whole doubled row again (truncated to n_exp).
    task automatic load_row(input logic [31:0] p0, p1, p2, p3, input int first, input int n_exp);
        logic [31:0] p[4];
        p = '{p0, p1, p2, p3};
        for (int i = first; i < 4; i++) a_in.push_back(p[i]);
        a_exp.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 8; i++)
                if (a_exp.size() < n_exp) a_exp.push_back(p[i/2]);
    endtask

    // Drive a_in into dut_a until every expected output has been seen.
    task automatic run_a(input int budget);
        int          cyc     = 0;
        int          n_taken = 0;
        int          first_x = -1;
        int          first_o = -1;
        logic        xfer;
        logic [31:0] e;
        bubbles  = 0;
        fd_cnt   = 0;
        fd_idx   = 0;
        out_cnt  = 0;
        rdy_bits = '0;
        while (a_exp.size() > 0) begin
            if (cyc >= budget) begin
                check("run_timeout", a_exp.size(), 0);
                a_exp.delete();
                break;
            end
            rdy_bits = {rdy_bits[14:0], a_i_ready};
            if (a_i_ready && n_taken == gap_after && gap_left > 0) begin
                a_i_valid = 1'b0;
                gap_left--;
            end else if (a_in.size() > 0) begin
                a_i_valid = 1'b1;
                a_i_data  = a_in[0];
            end else begin
                a_i_valid = 1'b0;
            end
            xfer = a_i_valid && a_i_ready;
            if (xfer && first_x < 0) first_x = cyc;
            @(negedge clk);
            cyc++;
            if (xfer) begin
                void'(a_in.pop_front());
                n_taken++;
            end
            if (a_o_valid) begin
                e = a_exp.pop_front();
                out_cnt++;
                check("a_data", a_o_data, e);
                if (first_o < 0) first_o = cyc;
            end else if (out_cnt > 0) begin
                bubbles++;
            end
            if (a_o_frame_done) begin
                fd_cnt++;
                fd_idx = out_cnt;
            end
        end
        lat = first_o - first_x;
    endtask

    initial begin
        logic [31:0] bexp[8];
        int          taken;
        logic        xfer;

        rst_n     = 1'b0;
        a_i_valid = 1'b0;
        a_i_data  = '0;
        b_i_valid = 1'b0;
        b_i_data  = '0;
        gap_after = -1;
        gap_left  = 0;
        repeat (2) @(negedge clk);
        check("rst_o_valid", a_o_valid, 0);
        check("rst_o_data", a_o_data, 0);
        check("rst_frame_done", a_o_frame_done, 0);
        check("rst_i_ready", a_i_ready, 1);
        check("rst_b_o_valid", b_o_valid, 0);
        rst_n = 1'b1;

        // Row 0: steady valid, ready toggles then drops for the 8 replay cycles.
        load_row(1, 2, 3, 4, 0, 16);
        run_a(100);
        check("s1_rdy_pattern", rdy_bits, 16'hAA00);
        check("s1_latency", lat, 1);
        check("s1_bubbles", bubbles, 0);
        check("s1_frame_done", fd_cnt, 0);
        check("s1_rdy_after_replay", a_i_ready, 1);

        // Row 1 (last of frame): 3-cycle gap before pixel 7, 0xDEAD held during replay.
        load_row(5, 6, 7, 8, 0, 16);
        a_in.push_back(32'hDEAD);
        gap_after = 2;
        gap_left  = 3;
        run_a(100);
        gap_after = -1;
        check("s2_bubbles", bubbles, 3);
        check("s2_frame_done_cnt", fd_cnt, 1);
        check("s2_frame_done_pos", fd_idx, 16);
        check("s2_dead_not_taken", a_in.size(), 1);
        check("s2_rdy_after_frame", a_i_ready, 1);

        // New frame starts with the held 0xDEAD pixel.
        load_row(32'hDEAD, 32'hB, 32'hC, 32'hD, 1, 16);
        run_a(100);
        check("s3_bubbles", bubbles, 0);
        check("s3_frame_done", fd_cnt, 0);

        // Stop mid-replay after the first copy of col 2, then reset.
        load_row(32'h11, 32'h12, 32'h13, 32'h14, 0, 13);
        run_a(100);
        check("s4_frame_done", fd_cnt, 0);
        a_i_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("midrst_o_valid", a_o_valid, 0);
        check("midrst_frame_done", a_o_frame_done, 0);
        check("midrst_i_ready", a_i_ready, 1);
        check("midrst_o_data", a_o_data, 0);
        rst_n = 1'b1;

        load_row(9, 10, 11, 12, 0, 16);
        run_a(100);
        check("s5_bubbles", bubbles, 0);
        check("s5_frame_done", fd_cnt, 0);

        load_row(13, 14, 15, 16, 0, 16);
        run_a(100);
        check("s6_frame_done_cnt", fd_cnt, 1);
        check("s6_frame_done_pos", fd_idx, 16);
        a_i_valid = 1'b0;

        // Minimum size 2x1: A,B -> A,A,B,B,A,A,B,B, frame done on the last B.
        bexp  = '{32'hA, 32'hA, 32'hB, 32'hB, 32'hA, 32'hA, 32'hB, 32'hB};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        taken = 0;
        for (int k = 1; k <= 9; k++) begin
            b_i_valid = (taken < 2);
            b_i_data  = (taken == 0) ? 32'hA : 32'hB;
            xfer      = b_i_valid && b_i_ready;
            @(negedge clk);
            if (xfer) taken++;
            if (k <= 8) begin
                check("b_o_valid", b_o_valid, 1);
                check("b_o_data", b_o_data, bexp[k-1]);
                check("b_frame_done", b_o_frame_done, (k == 8) ? 1 : 0);
            end else begin
                check("b_idle_o_valid", b_o_valid, 0);
                check("b_idle_frame_done", b_o_frame_done, 0);
            end
        end
        b_i_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
